display_scheduler: RTL and testbench
====================================

# display_scheduler

Time-shares the board's single four-digit seven-segment display among up to four on-chip requesters: PC, instruction count, register probe and ALU result. It round-robin arbitrates among active requesters and holds each grant for a fixed dwell period. It drives the 13-bit value input of the display driver and reports which source is shown. It sits between the RV32 core's debug taps and the display driver in the FPGA top level.

## Interface
- `DWELL_CYCLES`, default 100_000_000: clock cycles each grant is held (1 s at 100 MHz). Must be ≥ 2.
- `DEB_CYCLES`, default 1_000_000: button debounce stable-time in cycles. Used only with `DISP_MANUAL_EN`.
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  level request per source i; held high while source i wants display time.
- `src_val`  in  52  packed values; source i occupies bits [13i+12:13i].
- `btn`  in  1  raw push-button (asynchronous). Present in all builds; ignored without `DISP_MANUAL_EN`.
- `grant`  out  4  registered one-hot grant; all-zero when idle.
- `src_id`  out  2  index of granted source (last granted when idle).
- `num`  out  13  value to the display driver.
- `done`  out  4  one-cycle pulse on bit i when source i completes a full dwell.

## Operation
- States: IDLE, SHOW.
- Reset value of every output and internal register:
  - `grant`=0, `src_id`=0, `num`=0, `done`=0.
  - state IDLE, dwell counter 0, round-robin pointer `ptr`=0, debouncer cleared.
- Arbitration:
  - Search `req` starting at `ptr`, ascending mod 4; the first set bit wins.
  - On any new grant to source k, `ptr` becomes (k+1) mod 4.
- IDLE:
  - If any `req` bit is set, go to SHOW with the winner granted and the dwell counter at 0.
  - Otherwise stay in IDLE, `grant`=0, `num`=0.
- SHOW with source k granted:
  - Counter increments each cycle.
  - `num` <= `src_val[13k+12:13k]` every cycle (live tracking, one register stage).
- Expiry (counter == `DWELL_CYCLES`-1 and `req[k]`=1):
  - Pulse `done[k]`.
  - Re-arbitrate on the same edge. k may win again if it is the only requester; the counter restarts at 0.
  - If no requests remain, go to IDLE.
- Abort (`req[k]` falls before or on the expiry cycle):
  - No `done` pulse.
  - Re-arbitrate on the next edge, as from IDLE.
- Counter width is ceil(log2(`DWELL_CYCLES`)). The counter never wraps, because the expiry compare resets it.

## Timing
- Grant latency: `req` sampled high at edge n (from IDLE) gives `grant`/`src_id` valid after edge n, and `num` valid after edge n+1.
- A completed grant is held exactly `DWELL_CYCLES` cycles.
- Back-to-back grants have zero idle cycles. `done` is high in the first cycle of the following grant.
- `done` is never asserted in IDLE, and never for a source that is not being granted.
- Reset asserted mid-dwell: all outputs return to reset values immediately, asynchronously. On release, arbitration restarts from `ptr`=0.
- `req` changes for non-granted sources mid-dwell have no effect until the next arbitration.

## Configuration
- Macro: `DISP_MANUAL_EN`.
- Defined:
  - `btn` passes through a 2-FF synchronizer and a debouncer that requires `DEB_CYCLES` stable cycles.
  - Each debounced rising edge in SHOW aborts the current dwell with no `done` pulse. The next edge then arbitrates from `ptr`.
  - A press on the expiry cycle is absorbed, so there is a single advance.
  - A press in IDLE has no effect.
- Undefined: `btn` is ignored, no synchronizer or debouncer logic is built, and operation is purely time-based.

## Test plan
Simulate with `DWELL_CYCLES`=8, `DEB_CYCLES`=4.
- Reset, then `req`=4'b0010, `src_val[25:13]`=1234:
  - `grant`=4'b0010 and `src_id`=1 one edge after sampling.
  - `num`=1234 one edge later.
  - `done[1]` pulses every 8 cycles while `req` is held.
- `req`=4'b1011 steady:
  - Grant order is 0, 1, 3, 0, …, each grant exactly 8 cycles, with no gap.
  - `done` bit of the outgoing source is high in the first cycle of the next grant.
- Source 0 granted, `req[0]` dropped at dwell count 3 while `req[2]`=1:
  - No `done[0]` pulse.
  - `grant`=4'b0100 on the following edge.
- `req`=4'b0001, `src_val[12:0]` ramps 0→7 during the dwell:
  - `num` tracks each value with one cycle of lag.
- `rst_n` pulsed low at dwell count 5:
  - Outputs are zero immediately.
  - After release with `req`=4'b1100, source 2 is granted first.
- With `DISP_MANUAL_EN`, sources 0 and 1 requesting, `btn` held 6 cycles at dwell count 2:
  - Source 0 is aborted with no `done`, and source 1 is granted.
  - A 2-cycle glitch on `btn` causes no change.

Source files
------------

// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - request/value/grant bundle between debug taps and display_scheduler
//
// Signals:
//   req      [3:0]   level request per source (held while the source wants display time)
//   src_val  [51:0]  packed 13-bit source values, source i at [13i+12:13i]
//   grant    [3:0]   registered one-hot grant, zero when idle
//   src_id   [1:0]   index of the granted (or last granted) source
//   num      [12:0]  value presented to the display driver
//   done     [3:0]   one-cycle pulse when a source completes a full dwell
// Modports: master drives requests and values; slave (the scheduler) drives the rest.
interface display_scheduler_if;
    logic [3:0]  req;
    logic [51:0] src_val;
    logic [3:0]  grant;
    logic [1:0]  src_id;
    logic [12:0] num;
    logic [3:0]  done;

    modport master (output req, src_val, input grant, src_id, num, done);
    modport slave  (input req, src_val, output grant, src_id, num, done);
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin time-sharing of the seven-segment display among four sources
//
// Purpose: arbitrates among up to four requesters, holds each grant for DWELL_CYCLES
// cycles and forwards the granted source's value to the display driver.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   btn    raw push-button; used only when DISP_MANUAL_EN is defined
//   bus    display_scheduler_if.slave (req, src_val in; grant, src_id, num, done out)
// Optional feature macro: DISP_MANUAL_EN (synchronised, debounced button advances the display).
module display_scheduler #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int DEB_CYCLES   = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn,
    display_scheduler_if.slave  bus
);
    localparam int CW = $clog2(DWELL_CYCLES);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    src_id_q, src_id_d;
    logic [12:0]   num_q, num_d;
    logic [3:0]    done_q, done_d;
    logic          press;
    logic          rearb;
    logic [2:0]    win;

`ifdef DISP_MANUAL_EN
    localparam int DW = $clog2(DEB_CYCLES);

    logic          sync1_q, sync2_q, deb_q;
    logic [DW-1:0] deb_cnt_q;
    logic          deb_flip;

    // The synchronised level must differ from the debounced level for DEB_CYCLES
    // consecutive cycles before the debounced level follows it.
    assign deb_flip = (sync2_q != deb_q) && (deb_cnt_q == DW'(DEB_CYCLES - 1));
    assign press    = deb_flip && sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_flip) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end
`else
    logic btn_unused;
    assign btn_unused = btn & (DEB_CYCLES != 0);
    assign press      = 1'b0;
`endif

    // Returns {found, index}: first set request at or after p, ascending mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        // Walk offsets downwards so the smallest offset is the last to overwrite.
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        src_id_d = src_id_q;
        done_d   = '0;
        num_d    = '0;
        rearb    = 1'b0;
        win      = pick(bus.req, ptr_q);

        case (state_q)
            S_IDLE: rearb = 1'b1;
            S_SHOW: begin
                // Request loss takes precedence, then expiry (which absorbs a
                // simultaneous button press), then a manual advance.
                if (!bus.req[src_id_q]) begin
                    rearb = 1'b1;
                end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                    rearb            = 1'b1;
                    done_d[src_id_q] = 1'b1;
                end else if (press) begin
                    rearb = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            cnt_d = '0;
            if (win[2]) begin
                state_d  = S_SHOW;
                grant_d  = 4'b0001 << win[1:0];
                src_id_d = win[1:0];
                ptr_d    = win[1:0] + 2'd1;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        end

        // One register stage of live tracking while a grant continues across the edge.
        if (state_q == S_SHOW && state_d == S_SHOW) begin
            num_d = bus.src_val[13*src_id_q +: 13];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            src_id_q <= '0;
            num_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            src_id_q <= src_id_d;
            num_q    <= num_d;
            done_q   <= done_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.src_id = src_id_q;
    assign bus.num    = num_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - self-checking bench for display_scheduler
module tb_display_scheduler;
    localparam int DWELL = 8;

    logic clk;
    logic rst_n;
    logic btn;
    int   checks;
    int   passed;
    bit   model_en;

    display_scheduler_if bus ();

    display_scheduler #(.DWELL_CYCLES(DWELL), .DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Behavioural model: who owns the display, how long it has held it, where the
    // round-robin search starts next.
    int         m_busy, m_src, m_held, m_ptr, m_old, m_w;
    bit         m_was_busy, m_handover;
    logic [3:0] e_grant, e_done;
    logic [1:0] e_src;
    logic [12:0] e_num;

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_src = 0; m_held = 0; m_ptr = 0;
            e_grant = 0; e_done = 0; e_src = 0; e_num = 0;
        end else begin
            m_was_busy = (m_busy != 0);
            m_old      = m_src;
            m_handover = 0;
            e_done     = 0;
            if (m_busy == 0) m_handover = 1;
            else if (!bus.req[m_src]) m_handover = 1;
            else if (m_held == DWELL) begin
                m_handover = 1;
                e_done     = 4'(1 << m_src);
            end else m_held++;
            if (m_handover) begin
                m_w = first_req(bus.req, m_ptr);
                if (m_w >= 0) begin
                    m_busy = 1; m_src = m_w; m_held = 1; m_ptr = (m_w + 1) % 4;
                end else m_busy = 0;
            end
            e_num   = (m_was_busy && m_busy != 0) ? bus.src_val[m_old*13 +: 13] : 13'd0;
            e_grant = (m_busy != 0) ? 4'(1 << m_src) : 4'd0;
            e_src   = 2'(m_src);
        end
    end

    always @(negedge clk) begin
        if (rst_n && model_en) begin
            chk("model_grant",  32'(bus.grant),  32'(e_grant));
            chk("model_src_id", 32'(bus.src_id), 32'(e_src));
            chk("model_num",    32'(bus.num),    32'(e_num));
            chk("model_done",   32'(bus.done),   32'(e_done));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int order [4] = '{0, 1, 3, 0};

    initial begin
        checks = 0; passed = 0; model_en = 1'b1;
        rst_n = 1'b0; btn = 1'b0;
        bus.req = 4'b0000; bus.src_val = '0;
        repeat (3) @(negedge clk);
        chk("reset_grant",  32'(bus.grant),  0);
        chk("reset_src_id", 32'(bus.src_id), 0);
        chk("reset_num",    32'(bus.num),    0);
        chk("reset_done",   32'(bus.done),   0);
        rst_n = 1'b1;

        // Single requester: latency, value, periodic done.
        @(negedge clk);
        bus.src_val[25:13] = 13'd1234;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("t1_grant",  32'(bus.grant),  2);
        chk("t1_src_id", 32'(bus.src_id), 1);
        @(negedge clk);
        chk("t1_num", 32'(bus.num), 1234);
        for (int i = 2; i <= 17; i++) begin
            @(negedge clk);
            chk("t1_done", 32'(bus.done), (i % 8 == 0) ? 2 : 0);
        end

        // Three steady requesters: order 0,1,3,0 with no gap.
        do_reset();
        bus.req = 4'b1011;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            chk("t2_src_id", 32'(bus.src_id), order[j / 8]);
            chk("t2_grant",  32'(bus.grant),  1 << order[j / 8]);
            chk("t2_done",   32'(bus.done),
                (j > 0 && j % 8 == 0) ? (1 << order[j / 8 - 1]) : 0);
        end

        // Abort: source 0 drops at dwell count 3 while source 2 waits.
        do_reset();
        bus.req = 4'b0101;
        @(negedge clk);
        chk("t3_grant0", 32'(bus.grant), 1);
        repeat (3) @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t3_grant2", 32'(bus.grant), 4);
        chk("t3_done",   32'(bus.done),  0);

        // Live value tracking with one cycle of lag.
        do_reset();
        bus.src_val[12:0] = 13'd0;
        bus.req = 4'b0001;
        @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            bus.src_val[12:0] = 13'(i);
            @(negedge clk);
            chk("t4_num", 32'(bus.num), i);
        end

        // Asynchronous reset mid-dwell, then restart from pointer 0.
        do_reset();
        bus.req = 4'b0011;
        @(negedge clk);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_grant", 32'(bus.grant),  0);
        chk("t5_num",   32'(bus.num),    0);
        chk("t5_src",   32'(bus.src_id), 0);
        chk("t5_done",  32'(bus.done),   0);
        bus.req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_grant2", 32'(bus.grant),  4);
        chk("t5_src2",   32'(bus.src_id), 2);

`ifdef DISP_MANUAL_EN
        // Manual advance: 6-cycle press aborts source 0; later 2-cycle glitch ignored.
        do_reset();
        model_en = 1'b0;
        bus.req = 4'b0011;
        @(negedge clk);
        btn = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            chk("t6_grant", 32'(bus.grant), (i < 6) ? 1 : (i < 14) ? 2 : 1);
            chk("t6_done",  32'(bus.done),  (i == 14) ? 2 : 0);
            btn = (i < 6) || (i == 14) || (i == 15);
        end
        btn = 1'b0;
        do_reset();
        model_en = 1'b1;
`endif

        // Idle tail: no grant, no done.
        do_reset();
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);
        chk("idle_grant", 32'(bus.grant), 0);
        chk("idle_done",  32'(bus.done),  0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
